// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/execute controller placed upstream of the
// A/D/A* memory block. Fetches 16-bit instructions over a req/valid handshake,
// decodes them, computes the ALU result, drives store flags and owns the pc.
// Optional build macro: CPU_SEQUENCER_HALT_DETECT_EN adds a HALT state entered
// after an unconditional jump-to-self; without it halted is tied to 0.

package cpu_sequencer_pkg;
  typedef struct packed {
    logic a;
    logic d;
    logic a_star;
  } dst_flag_t;
endpackage

module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [WIDTH-1:0]    imem_rdata,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    D,
  input  logic [WIDTH-1:0]    A_star,
  output logic [WIDTH-1:0]    x,
  output dst_flag_t           dst,
  output logic [PC_WIDTH-1:0] pc,
  output logic                exec,
  output logic                halted
);

`ifdef CPU_SEQUENCER_HALT_DETECT_EN
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
`endif

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]    ir_q, ir_d;

  logic [WIDTH-1:0]        alu_r;
  logic signed [WIDTH-1:0] alu_r_s;
  logic                    take_jump;
  logic [PC_WIDTH-1:0]     a_pc;

  // Logic/arith function select; all results wrap modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] alu_fn(input logic u, input logic [1:0] op,
                                              input logic [WIDTH-1:0] xo,
                                              input logic [WIDTH-1:0] yo);
    logic [WIDTH-1:0] r;
    case ({u, op})
      3'b000:  r = xo & yo;
      3'b001:  r = xo | yo;
      3'b010:  r = xo ^ yo;
      3'b011:  r = ~xo;
      3'b100:  r = xo + yo;
      3'b101:  r = xo + WIDTH'(1);
      3'b110:  r = xo - yo;
      default: r = xo - WIDTH'(1);
    endcase
    return r;
  endfunction

  // Jump decision on the result interpreted as two's complement.
  function automatic logic jump_fn(input logic [2:0] j, input logic signed [WIDTH-1:0] r);
    return (j[2] & (r < 0)) | (j[1] & (r == 0)) | (j[0] & (r > 0));
  endfunction

  // Operand routing: Y selects A or A*, optional swap, then optional zeroing of X.
  always_comb begin
    logic [WIDTH-1:0] y0, xs, ys;
    y0        = ir_q[12] ? A_star : A;
    xs        = ir_q[6] ? y0 : D;
    ys        = ir_q[6] ? D : y0;
    if (ir_q[7]) xs = '0;
    alu_r     = alu_fn(ir_q[10], ir_q[9:8], xs, ys);
    alu_r_s   = alu_r;
    take_jump = ir_q[15] & jump_fn(ir_q[2:0], alu_r_s);
    a_pc      = PC_WIDTH'(A);
  end

  // Next-state, next-pc and EXEC-cycle store outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    x       = '0;
    dst     = '0;
    case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (ir_q[15]) begin
          x   = alu_r;
          dst = dst_flag_t'(ir_q[5:3]);
        end else begin
          x   = {1'b0, ir_q[WIDTH-2:0]};
          dst = '{a: 1'b1, d: 1'b0, a_star: 1'b0};
        end
        pc_d    = take_jump ? a_pc : pc_q + PC_WIDTH'(1);
        state_d = run ? FETCH : IDLE;
`ifdef CPU_SEQUENCER_HALT_DETECT_EN
        if (ir_q[15] && (ir_q[2:0] == 3'b111) && (a_pc == pc_q)) state_d = HALT;
`endif
      end
`ifdef CPU_SEQUENCER_HALT_DETECT_EN
      HALT: state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, pc and instruction registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign exec      = (state_q == EXEC);
`ifdef CPU_SEQUENCER_HALT_DETECT_EN
  assign halted    = (state_q == HALT);
`else
  assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer. Inputs change and outputs
// are sampled on the falling clock edge.

module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, run, imem_req, imem_valid, exec, halted;
  logic [15:0] imem_addr, imem_rdata, A, D, A_star, x, pc;
  dst_flag_t   dst;

  int pass_cnt = 0;
  int total_cnt = 0;

  cpu_sequencer #(.WIDTH(16), .PC_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .A(A), .D(D), .A_star(A_star),
    .x(x), .dst(dst), .pc(pc), .exec(exec), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Present an instruction while in FETCH; returns at the EXEC-cycle falling edge.
  task automatic fetch_exec(input logic [15:0] instr, input logic [15:0] a_v,
                            input logic [15:0] d_v, input logic [15:0] as_v);
    imem_valid = 1'b1;
    imem_rdata = instr;
    A = a_v; D = d_v; A_star = as_v;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; imem_valid = 1'b1; imem_rdata = 16'h0005;
    A = '0; D = '0; A_star = '0;
    repeat (3) step();
    total_cnt++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", pc); else pass_cnt++;
    total_cnt++; if ({imem_req, exec, halted} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {imem_req, exec, halted}); else pass_cnt++;
    total_cnt++; if ({x, dst} !== 19'h0) $display("FAIL reset_store: got x=%h dst=%b want 0", x, dst); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) $display("FAIL first_fetch: got req=%b addr=%h want 1/0000", imem_req, imem_addr); else pass_cnt++;
    step();
    total_cnt++; if (exec !== 1'b1 || x !== 16'h0005 || dst !== 3'b100) $display("FAIL const_exec: got exec=%b x=%h dst=%b want 1/0005/100", exec, x, dst); else pass_cnt++;
    step();
    total_cnt++; if (pc !== 16'h0001 || exec !== 1'b0) $display("FAIL const_pc: got pc=%h exec=%b want 0001/0", pc, exec); else pass_cnt++;
  endtask

  task automatic test_alu();
    fetch_exec(16'h8410, 16'h0005, 16'h0003, 16'h0000);   // D+A -> D
    total_cnt++; if (x !== 16'h0008 || dst !== 3'b010) $display("FAIL add: got x=%h dst=%b want 0008/010", x, dst); else pass_cnt++;
    step();
    total_cnt++; if (pc !== 16'h0002) $display("FAIL add_pc: got %h want 0002", pc); else pass_cnt++;
    fetch_exec(16'h8490, 16'h0005, 16'h0003, 16'h0000);   // zx: 0+A -> D
    total_cnt++; if (x !== 16'h0005 || dst !== 3'b010) $display("FAIL zx_add: got x=%h dst=%b want 0005/010", x, dst); else pass_cnt++;
    step();
    fetch_exec(16'h8010, 16'h0F3C, 16'h00F0, 16'h0000);   // D&A -> D
    total_cnt++; if (x !== 16'h0030 || dst !== 3'b010) $display("FAIL and: got x=%h dst=%b want 0030/010", x, dst); else pass_cnt++;
    step();
    fetch_exec(16'h9108, 16'h0000, 16'h0034, 16'h1200);   // D|A* -> A*
    total_cnt++; if (x !== 16'h1234 || dst !== 3'b001) $display("FAIL or_astar: got x=%h dst=%b want 1234/001", x, dst); else pass_cnt++;
    step();
    total_cnt++; if (pc !== 16'h0005) $display("FAIL seq_pc: got %h want 0005", pc); else pass_cnt++;
  endtask

  task automatic test_jump();
    fetch_exec(16'h8679, 16'h0003, 16'h0005, 16'h0000);   // swapped A-D, all dst, jgt not taken
    total_cnt++; if (x !== 16'hFFFE || dst !== 3'b111) $display("FAIL swap_sub: got x=%h dst=%b want fffe/111", x, dst); else pass_cnt++;
    step();
    total_cnt++; if (pc !== 16'h0006) $display("FAIL jgt_not_taken: got pc=%h want 0006", pc); else pass_cnt++;
    fetch_exec(16'h8602, 16'h0040, 16'h0040, 16'h0000);   // D-A, jeq
    total_cnt++; if (x !== 16'h0000 || dst !== 3'b000 || exec !== 1'b1) $display("FAIL jeq_exec: got x=%h dst=%b exec=%b want 0000/000/1", x, dst, exec); else pass_cnt++;
    step();
    total_cnt++; if (pc !== 16'h0040) $display("FAIL jeq_taken: got pc=%h want 0040", pc); else pass_cnt++;
  endtask

  task automatic test_stall_and_reset();
    imem_valid = 1'b0; imem_rdata = 16'h0123;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || dst !== 3'b000 || exec !== 1'b0)
        $display("FAIL stall_%0d: got req=%b addr=%h dst=%b exec=%b want 1/0040/000/0", i, imem_req, imem_addr, dst, exec);
      else pass_cnt++;
    end
    fetch_exec(16'h0123, 16'h0000, 16'h0000, 16'h0000);
    total_cnt++; if (exec !== 1'b1 || x !== 16'h0123 || dst !== 3'b100) $display("FAIL stall_exec: got exec=%b x=%h dst=%b want 1/0123/100", exec, x, dst); else pass_cnt++;
    rst = 1'b1;
    step();
    total_cnt++; if (pc !== 16'h0000 || exec !== 1'b0 || imem_req !== 1'b0 || dst !== 3'b000 || x !== 16'h0) $display("FAIL rst_in_exec: got pc=%h exec=%b req=%b dst=%b x=%h want 0000/0/0/000/0000", pc, exec, imem_req, dst, x); else pass_cnt++;
    rst = 1'b0; run = 1'b0;
    step();
    total_cnt++; if (imem_req !== 1'b0 || exec !== 1'b0) $display("FAIL idle_hold: got req=%b exec=%b want 0/0", imem_req, exec); else pass_cnt++;
    run = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    fetch_exec(16'h8007, 16'hFFFF, 16'h0000, 16'h0000);   // unconditional jump to ffff
    step();
    total_cnt++; if (pc !== 16'hFFFF) $display("FAIL jmp_ffff: got pc=%h want ffff", pc); else pass_cnt++;
    fetch_exec(16'h0001, 16'h0000, 16'h0000, 16'h0000);
    run = 1'b0;
    step();
    total_cnt++; if (pc !== 16'h0000 || imem_req !== 1'b0) $display("FAIL pc_wrap_idle: got pc=%h req=%b want 0000/0", pc, imem_req); else pass_cnt++;
    run = 1'b1;
    step();
  endtask

  task automatic test_halt();
    fetch_exec(16'h8007, 16'h0007, 16'h0000, 16'h0000);
    step();
    total_cnt++; if (pc !== 16'h0007) $display("FAIL jmp_7: got pc=%h want 0007", pc); else pass_cnt++;
    fetch_exec(16'h8007, 16'h0007, 16'h0000, 16'h0000);   // jump-to-self
    total_cnt++; if (exec !== 1'b1 || x !== 16'h0000 || dst !== 3'b000 || halted !== 1'b0) $display("FAIL self_exec: got exec=%b x=%h dst=%b halted=%b want 1/0000/000/0", exec, x, dst, halted); else pass_cnt++;
`ifdef CPU_SEQUENCER_HALT_DETECT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || exec !== 1'b0 || dst !== 3'b000)
        $display("FAIL halt_%0d: got halted=%b req=%b exec=%b dst=%b want 1/0/0/000", i, halted, imem_req, exec, dst);
      else pass_cnt++;
    end
`else
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0007 || halted !== 1'b0)
        $display("FAIL refetch_%0d: got req=%b addr=%h halted=%b want 1/0007/0", i, imem_req, imem_addr, halted);
      else pass_cnt++;
      fetch_exec(16'h8007, 16'h0007, 16'h0000, 16'h0000);
    end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jump();
    test_stall_and_reset();
    test_wrap();
    test_halt();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
